// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle for one subordinate slot of the decoder/mux.
// The master side drives address/control/write data and the muxed Hready;
// the slave side returns Hreadyout, Hresp and Hrdata.
interface ahb_slave_mem_if;
    logic        Hsel;
    logic [31:0] Haddr;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [31:0] Hwdata;
    logic        Hready;
    logic        Hreadyout;
    logic        Hresp;
    logic [31:0] Hrdata;

    modport slave (
        input  Hsel, Haddr, Htrans, Hwrite, Hsize, Hwdata, Hready,
        output Hreadyout, Hresp, Hrdata
    );

    modport master (
        output Hsel, Haddr, Htrans, Hwrite, Hsize, Hwdata, Hready,
        input  Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: word-addressed AHB-Lite subordinate backed by a register-file memory.
// Pipelined address/data phases, 32-bit word accesses only, two-cycle ERROR response
// for illegal transfers (wrong size, misaligned, or beyond 4*DEPTH bytes).
// Optional feature macro: AHB_SLAVE_WAIT_EN inserts WAIT_CYCLES wait states per legal
// transfer; without it every legal transfer is zero-wait and WAIT_CYCLES is ignored.
module ahb_slave_mem #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           Hclk,
    input  logic           Hreset,
    ahb_slave_mem_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StErr1,
        StErr2
    } state_e;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ahb_slave_mem: DEPTH must be a power of two in 2..256");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("ahb_slave_mem: WAIT_CYCLES must be in 0..15");
    end

    state_e        r_state;
    state_e        w_state_next;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_idx;
    logic          r_write;
    logic [31:0]   r_rdata;

    logic          w_readyout;
    logic          w_resp;
    logic          w_wait_zero;
    logic          w_accept;
    logic          w_legal;
    logic          w_take;
    logic          w_wr_done;
    logic [AW-1:0] w_idx;
    logic          w_unused_htrans0;

`ifdef AHB_SLAVE_WAIT_EN
    logic [3:0]    r_wait_cnt;
`endif

    // Only NONSEQ/SEQ carry a transfer; IDLE and BUSY differ in Htrans[0] alone.
    assign w_unused_htrans0 = bus.Htrans[0];

    // Address-phase decode.
    assign w_accept = bus.Hsel && bus.Hready && bus.Htrans[1];
    assign w_idx    = bus.Haddr[AW+1:2];
    assign w_legal  = (bus.Hsize == 3'b010) && (bus.Haddr[1:0] == 2'b00)
                   && (bus.Haddr[31:AW+2] == '0);

    // A new address phase is only taken when our own data phase (if any) is finishing,
    // which keeps the hold rule intact even if Hready were asserted out of turn.
    assign w_take    = w_accept && w_readyout;
    assign w_wr_done = (r_state == StData) && w_readyout && r_write;

`ifdef AHB_SLAVE_WAIT_EN
    assign w_wait_zero = (r_wait_cnt == 4'd0);
`else
    assign w_wait_zero = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: ERR1 always proceeds to ERR2; every other state moves on only when
    // its data phase completes, to whatever the same-edge address phase calls for.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StErr1: w_state_next = StErr2;
            default: begin
                if (w_readyout) begin
                    if (w_accept) begin
                        w_state_next = w_legal ? StData : StErr1;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
        endcase
    end

    // FSM outputs: ready/response per state.
    always_comb begin
        w_readyout = 1'b1;
        w_resp     = 1'b0;
        case (r_state)
            StIdle: begin
                w_readyout = 1'b1;
                w_resp     = 1'b0;
            end
            StData: begin
                w_readyout = w_wait_zero;
                w_resp     = 1'b0;
            end
            StErr1: begin
                w_readyout = 1'b0;
                w_resp     = 1'b1;
            end
            StErr2: begin
                w_readyout = 1'b1;
                w_resp     = 1'b1;
            end
            default: begin
                w_readyout = 1'b1;
                w_resp     = 1'b0;
            end
        endcase
    end

    // Capture the accepted address phase for the following data phase.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_idx   <= '0;
            r_write <= 1'b0;
        end else if (w_take) begin
            r_idx   <= w_idx;
            r_write <= bus.Hwrite;
        end
    end

`ifdef AHB_SLAVE_WAIT_EN
    // Wait-state counter: reloaded on each legal accept, counts down to zero.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_wait_cnt <= 4'd0;
        end else if (w_take && w_legal) begin
            r_wait_cnt <= 4'(WAIT_CYCLES);
        end else if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end
`endif

    // Memory array: cleared on reset, written when a write data phase completes.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_done) begin
            r_mem[r_idx] <= bus.Hwdata;
        end
    end

    // Read data register: loaded at a legal read accept, forwarding a same-edge write.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_rdata <= '0;
        end else if (w_take && w_legal && !bus.Hwrite) begin
            if (w_wr_done && (r_idx == w_idx)) begin
                r_rdata <= bus.Hwdata;
            end else begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    assign bus.Hreadyout = w_readyout;
    assign bus.Hresp     = w_resp;
    assign bus.Hrdata    = r_rdata;

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

Word-addressed AHB-Lite subordinate (responder) backed by a small register-file memory. It is the slave end of the bus that `AHB_module` and its benches drive. It accepts pipelined address/data phases, performs 32-bit reads and writes, inserts optional wait states, and returns a two-cycle ERROR response for illegal transfers. The block plugs into one slave-select slot of the AHB decoder/mux.

## Interface
- `DEPTH`, 16: number of 32-bit words; power of two, 2..256.
- `WAIT_CYCLES`, 2: wait states per transfer, 0..15. Used only when `AHB_SLAVE_WAIT_EN` is defined.
- `Hclk` in 1: clock; all state updates on the rising edge.
- `Hreset` in 1: asynchronous, active-high reset.
- `Hsel` in 1: slave select from the decoder.
- `Haddr` in 32: byte address.
- `Htrans` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Hwrite` in 1: 1 = write.
- `Hsize` in 3: only 3'b010 (word) is legal.
- `Hwdata` in 32: write data, valid in the data phase.
- `Hready` in 1: bus-level ready (muxed). Tie to `Hreadyout` in single-slave benches.
- `Hreadyout` out 1: 1 = data phase completes this cycle.
- `Hresp` out 1: 0 OKAY, 1 ERROR.
- `Hrdata` out 32: read data.

## Operation
- **Accept condition:** an address phase is accepted at an edge with `Hsel && Hready && Htrans[1]`. The block captures the word index `Haddr[log2(DEPTH)+1:2]`, `Hwrite` and a legality flag.
- **Illegal transfer:** `Hsize != 3'b010`, `Haddr[1:0] != 0`, or `Haddr >= 4*DEPTH`. No memory access takes place.
- **IDLE/BUSY:** IDLE or BUSY with `Hsel` is ignored. The response is zero-wait OKAY.
- **States:**
  - ST_IDLE: no data phase pending. Outputs `Hreadyout=1`, `Hresp=0`.
    - Legal accept → ST_DATA.
    - Illegal accept → ST_ERR1.
  - ST_DATA: `Hreadyout = (wait_cnt == 0)`, `Hresp=0`. `wait_cnt` decrements each cycle while nonzero.
    - When `Hreadyout=1`, a write stores `Hwdata` into `mem[index]` at that edge.
    - On completion, the next state is ST_DATA, ST_ERR1 or ST_IDLE, according to any address phase accepted on the same edge (pipelined back-to-back).
  - ST_ERR1: `Hreadyout=0`, `Hresp=1` → ST_ERR2.
  - ST_ERR2: `Hreadyout=1`, `Hresp=1`. Next state follows the same rule as ST_DATA completion.
- **Read data:** `Hrdata` is a register loaded from `mem[index]` at the accept edge of a legal read.
  - Forwarding: if a write data phase completes on that same edge to the same index, `Hrdata` loads `Hwdata`.
  - `Hrdata` holds its value until the next legal read accept.
  - `Hrdata` is 0 after reset. It is unchanged by writes, errors and IDLE cycles.
- **Reset:** `Hreset` clears all memory words to 0 and forces ST_IDLE, `wait_cnt=0`, `Hreadyout=1`, `Hresp=0`, `Hrdata=0`. A reset during a pending write aborts it; memory stays at 0.

## Timing
- **Zero-wait:** the address phase is cycle N and the data phase is cycle N+1 with `Hreadyout=1`. Write data is stored at the end of N+1. Read data is valid throughout N+1.
- **With waits:** `Hreadyout` is low for exactly `WAIT_CYCLES` cycles after the accept edge, then high for one cycle.
- **ERROR:** always exactly 2 data-phase cycles (0/1 then 1/1), regardless of `WAIT_CYCLES`.
- **Hold rule:** while `Hready=0`, no new address phase is accepted. `Haddr` and `Htrans` changes are ignored.
- **Back-to-back:** sustained throughput is 1 transfer/cycle at zero wait.

## Configuration
- Macro `AHB_SLAVE_WAIT_EN`:
  - Defined: `wait_cnt` (4 bits) is loaded with `WAIT_CYCLES` on each legal accept.
  - Undefined: the counter logic is not compiled, `WAIT_CYCLES` is ignored, and every legal transfer is zero-wait. ERROR behaviour is identical in both builds.

## Test plan
- **Write then read:** write 32'd5 to 0x04, then NONSEQ read 0x04 → `Hrdata=5`, `Hresp=0`, zero wait (macro off).
- **Pipelined forwarding:** write 0xA to 0x08 immediately followed by a read of 0x08 (read address phase during the write data phase) → `Hrdata=0xA`.
- **Out-of-range:** write 0x1234 to 0x40 with DEPTH=16 → `Hreadyout` 0 then 1 with `Hresp=1` both cycles. A read of any address afterwards shows no 0x1234 stored.
- **Illegal size/alignment:** `Hsize=3'b000` at 0x0C, and a word access at 0x0D → ERROR each time, memory unchanged.
- **Wait states:** macro on, WAIT_CYCLES=2, read 0x04 → `Hreadyout` low 2 cycles then high with correct data. IDLE with `Hsel=1` → `Hreadyout` stays 1.
- **Reset mid-wait:** assert `Hreset` during the second wait cycle of a write of 0x77 to 0x10 → outputs return to reset values immediately, and a later read of 0x10 returns 0.
